// File: rtl/elevator_pkg.sv
// Shared elevator types: floor labels, scheduler states and SCAN helper functions.
package elevator_pkg;

  localparam int NUM_FLOORS = 3;

  localparam logic [1:0] F1 = 2'b00;
  localparam logic [1:0] F2 = 2'b01;
  localparam logic [1:0] F3 = 2'b10;

  typedef enum logic [1:0] {IDLE, UP, DOWN, SERVE} sched_state_t;

  function automatic logic [2:0] above_mask(input logic [1:0] cur);
    case (cur)
      F1:      return 3'b110;
      F2:      return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] below_mask(input logic [1:0] cur);
    case (cur)
      F3:      return 3'b011;
      F2:      return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Only the middle floor can sit between cur and the far end.
  function automatic logic [1:0] lowest_above(input logic mid_pending, input logic [1:0] cur);
    return (cur == F1 && mid_pending) ? F2 : F3;
  endfunction

  function automatic logic [1:0] highest_below(input logic mid_pending, input logic [1:0] cur);
    return (cur == F3 && mid_pending) ? F2 : F1;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw button to single-cycle press pulse: 2-flop synchronizer, optional debounce
// (REQUEST_SCHED_DEBOUNCE_EN), then a registered rising-edge detector.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic button_reset_n,
  input  logic button_raw,
  output logic press
);

`ifdef REQUEST_SCHED_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  logic sync1_reg;
  logic sync2_reg;
  logic level;
  logic level_d_reg;
  logic press_reg;

  always_ff @(posedge clk or negedge button_reset_n) begin
    if (!button_reset_n) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      level_d_reg <= 1'b0;
      press_reg   <= 1'b0;
    end else begin
      sync1_reg   <= button_raw;
      sync2_reg   <= sync1_reg;
      level_d_reg <= level;
      press_reg   <= level & ~level_d_reg;
    end
  end

  generate
    if (DB_EN && DEBOUNCE_CYCLES > 0) begin : g_debounce
      localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      logic [CNT_W-1:0] cnt_reg;
      logic             level_reg;

      // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      always_ff @(posedge clk or negedge button_reset_n) begin
        if (!button_reset_n) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end else if (sync2_reg == level_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt_reg   <= '0;
          level_reg <= sync2_reg;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end

      assign level = level_reg;
    end else begin : g_pass
      assign level = sync2_reg;
    end
  endgenerate

  assign press = press_reg;

endmodule

// File: rtl/request_scheduler.sv
// Elevator request stage: latches floor calls and picks the next goal with a SCAN policy.
// Optional button debounce is compiled in with REQUEST_SCHED_DEBOUNCE_EN.
module request_scheduler
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DWELL_TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       button_reset_n,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       floor1,
  input  logic       floor2,
  input  logic       floor3,
  input  logic       moving,
  input  logic       door,
  input  logic       sos_mode,
  input  logic       weight_limit_exceeded,
  output logic       led1,
  output logic       led2,
  output logic       led3,
  output logic [1:0] goal_floor,
  output logic       direction
);

  localparam int TMR_W = $clog2(DWELL_TIMEOUT + 1);

  logic [2:0]       raw_buttons;
  logic [2:0]       press;
  logic [2:0]       floor_vec;
  logic             floor_valid;
  logic [1:0]       floor_idx;
  logic [2:0]       cur_mask;
  logic             at_cur;
  logic             any_above;
  logic             any_below;
  logic [2:0]       accept;

  sched_state_t     state_reg;
  logic [2:0]       pending_reg;
  logic [1:0]       cur_reg;
  logic [1:0]       goal_floor_reg;
  logic             direction_reg;
  logic [TMR_W-1:0] timer_reg;
  logic             door_seen_reg;

  assign raw_buttons = {button3, button2, button1};
  assign floor_vec   = {floor3, floor2, floor1};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_btn
      button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
        .clk            (clk),
        .button_reset_n (button_reset_n),
        .button_raw     (raw_buttons[gi]),
        .press          (press[gi])
      );
    end
  endgenerate

  always_comb begin
    floor_valid = 1'b0;
    floor_idx   = F1;
    case (floor_vec)
      3'b001:  begin floor_valid = 1'b1; floor_idx = F1; end
      3'b010:  begin floor_valid = 1'b1; floor_idx = F2; end
      3'b100:  begin floor_valid = 1'b1; floor_idx = F3; end
      default: begin floor_valid = 1'b0; floor_idx = F1; end
    endcase
  end

  assign cur_mask  = 3'b001 << cur_reg;
  assign at_cur    = |(pending_reg & cur_mask);
  assign any_above = |(pending_reg & above_mask(cur_reg));
  assign any_below = |(pending_reg & below_mask(cur_reg));

  // A call for the floor being served (or with the door open) is already satisfied.
  always_comb begin
    accept = press;
    if (sos_mode)
      accept = 3'b000;
    else if (state_reg == SERVE || door)
      accept = press & ~cur_mask;
  end

  always_ff @(posedge clk or negedge button_reset_n) begin
    if (!button_reset_n) begin
      state_reg      <= IDLE;
      pending_reg    <= 3'b000;
      cur_reg        <= F1;
      goal_floor_reg <= F1;
      direction_reg  <= 1'b0;
      timer_reg      <= '0;
      door_seen_reg  <= 1'b0;
    end else begin
      if (floor_valid)
        cur_reg <= floor_idx;

      if (sos_mode) begin
        state_reg      <= IDLE;
        pending_reg    <= 3'b000;
        goal_floor_reg <= cur_reg;
        direction_reg  <= 1'b0;
        timer_reg      <= '0;
        door_seen_reg  <= 1'b0;
      end else if (weight_limit_exceeded) begin
        pending_reg    <= pending_reg | accept;
        goal_floor_reg <= cur_reg;
      end else begin
        pending_reg <= pending_reg | accept;
        case (state_reg)
          IDLE, UP, DOWN: begin
            if (!(|pending_reg)) begin
              state_reg      <= IDLE;
              goal_floor_reg <= cur_reg;
              direction_reg  <= 1'b0;
            end else if (at_cur && !moving) begin
              state_reg      <= SERVE;
              goal_floor_reg <= cur_reg;
              direction_reg  <= 1'b0;
              timer_reg      <= '0;
              door_seen_reg  <= 1'b0;
            end else if (any_above && (state_reg != DOWN || !any_below)) begin
              state_reg      <= UP;
              goal_floor_reg <= lowest_above(pending_reg[1], cur_reg);
              direction_reg  <= 1'b1;
            end else if (any_below) begin
              state_reg      <= DOWN;
              goal_floor_reg <= highest_below(pending_reg[1], cur_reg);
              direction_reg  <= 1'b0;
            end else begin
              // Only the current floor is pending while the cabin still moves.
              state_reg      <= IDLE;
              goal_floor_reg <= cur_reg;
              direction_reg  <= 1'b0;
            end
          end
          SERVE: begin
            goal_floor_reg <= cur_reg;
            direction_reg  <= 1'b0;
            if (door && !door_seen_reg) begin
              door_seen_reg <= 1'b1;
              pending_reg   <= (pending_reg | accept) & ~cur_mask;
            end else if (!door && door_seen_reg) begin
              state_reg <= IDLE;
            end else if (!door_seen_reg && timer_reg == TMR_W'(DWELL_TIMEOUT - 1)) begin
              pending_reg <= (pending_reg | accept) & ~cur_mask;
              state_reg   <= IDLE;
            end else if (!door_seen_reg) begin
              timer_reg <= timer_reg + TMR_W'(1);
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign led1       = pending_reg[0];
  assign led2       = pending_reg[1];
  assign led3       = pending_reg[2];
  assign goal_floor = goal_floor_reg;
  assign direction  = direction_reg;

endmodule

// File: tb/tb_request_scheduler.sv
// Directed self-checking bench for request_scheduler; debounce cases run only
// when REQUEST_SCHED_DEBOUNCE_EN is defined.
module tb_request_scheduler;
  import elevator_pkg::*;

`ifdef REQUEST_SCHED_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       button_reset_n;
  logic       button1, button2, button3;
  logic       floor1, floor2, floor3;
  logic       moving, door, sos_mode, weight_limit_exceeded;
  logic       led1, led2, led3;
  logic [1:0] goal_floor;
  logic       direction;

  int checks = 0;
  int errors = 0;

  request_scheduler #(.DEBOUNCE_CYCLES(4), .DWELL_TIMEOUT(16)) dut (
    .clk                   (clk),
    .button_reset_n        (button_reset_n),
    .button1               (button1),
    .button2               (button2),
    .button3               (button3),
    .floor1                (floor1),
    .floor2                (floor2),
    .floor3                (floor3),
    .moving                (moving),
    .door                  (door),
    .sos_mode              (sos_mode),
    .weight_limit_exceeded (weight_limit_exceeded),
    .led1                  (led1),
    .led2                  (led2),
    .led3                  (led3),
    .goal_floor            (goal_floor),
    .direction             (direction)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    $display("%0t check %s observed %0h expected %0h", $time, tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] leds();
    return {5'b00000, led3, led2, led1};
  endfunction

  initial begin
    button_reset_n = 1'b0;
    {button1, button2, button3} = 3'b000;
    {floor3, floor2, floor1} = 3'b001;
    moving = 1'b0; door = 1'b0; sos_mode = 1'b0; weight_limit_exceeded = 1'b0;
    step(2);
    chk("rst_leds", leds(), 8'h00);
    chk("rst_goal", 8'(goal_floor), 8'h00);
    chk("rst_dir", 8'(direction), 8'h00);
    chk("rst_state", 8'(dut.state_reg), 8'(IDLE));
    button_reset_n = 1'b1;
    step(1);

    // Call F3 from F1
    button3 = 1'b1;
    step(LAT);
    chk("t1_led3_early", leds(), 8'h00);
    step(1);
    chk("t1_led3_set", leds(), 8'h04);
    chk("t1_still_idle", 8'(dut.state_reg), 8'(IDLE));
    button3 = 1'b0;
    step(1);
    chk("t1_state_up", 8'(dut.state_reg), 8'(UP));
    chk("t1_dir_up", 8'(direction), 8'h01);
    chk("t1_goal_f3", 8'(goal_floor), 8'h02);
    moving = 1'b1; {floor3, floor2, floor1} = 3'b010;
    step(2);
    chk("t1_pass_f2_goal", 8'(goal_floor), 8'h02);
    {floor3, floor2, floor1} = 3'b100; moving = 1'b0;
    step(2);
    chk("t1_serve", 8'(dut.state_reg), 8'(SERVE));
    chk("t1_serve_dir", 8'(direction), 8'h00);
    door = 1'b1;
    step(1);
    chk("t1_led3_clear", leds(), 8'h00);
    step(1);
    door = 1'b0;
    step(1);
    chk("t1_idle", 8'(dut.state_reg), 8'(IDLE));

    // At F2, calls for F1 and F3 in the same cycle
    {floor3, floor2, floor1} = 3'b010;
    step(2);
    button1 = 1'b1; button3 = 1'b1;
    step(LAT + 1);
    chk("t2_both_leds", leds(), 8'h05);
    button1 = 1'b0; button3 = 1'b0;
    step(1);
    chk("t2_up", 8'(dut.state_reg), 8'(UP));
    chk("t2_goal_f3", 8'(goal_floor), 8'h02);
    {floor3, floor2, floor1} = 3'b100;
    step(2);
    chk("t2_serve_f3", 8'(dut.state_reg), 8'(SERVE));
    door = 1'b1;
    step(1);
    chk("t2_led3_clear", leds(), 8'h01);
    door = 1'b0;
    step(1);
    chk("t2_idle", 8'(dut.state_reg), 8'(IDLE));
    step(1);
    chk("t2_down", 8'(dut.state_reg), 8'(DOWN));
    chk("t2_goal_f1", 8'(goal_floor), 8'h00);
    chk("t2_dir_down", 8'(direction), 8'h00);

    // Arrive at F1 and serve with a 2-cycle door pulse
    {floor3, floor2, floor1} = 3'b001;
    step(2);
    chk("t3_serve_f1", 8'(dut.state_reg), 8'(SERVE));
    chk("t3_goal_cur", 8'(goal_floor), 8'h00);
    door = 1'b1;
    step(1);
    chk("t3_led1_clear", leds(), 8'h00);
    chk("t3_serve_door1", 8'(dut.state_reg), 8'(SERVE));
    step(1);
    chk("t3_serve_door2", 8'(dut.state_reg), 8'(SERVE));
    door = 1'b0;
    step(1);
    chk("t3_idle", 8'(dut.state_reg), 8'(IDLE));

    // Dwell timeout with door never opening
    button1 = 1'b1;
    step(LAT + 1);
    chk("t4_led1", leds(), 8'h01);
    button1 = 1'b0;
    step(1);
    chk("t4_serve", 8'(dut.state_reg), 8'(SERVE));
    step(15);
    chk("t4_serve_at15", 8'(dut.state_reg), 8'(SERVE));
    chk("t4_led1_at15", leds(), 8'h01);
    step(1);
    chk("t4_idle_at16", 8'(dut.state_reg), 8'(IDLE));
    chk("t4_led1_forced", leds(), 8'h00);

    // Emergency flush
    button2 = 1'b1; button3 = 1'b1;
    step(LAT + 1);
    chk("t5_leds23", leds(), 8'h06);
    button2 = 1'b0; button3 = 1'b0;
    step(1);
    chk("t5_up", 8'(dut.state_reg), 8'(UP));
    chk("t5_goal_f2", 8'(goal_floor), 8'h01);
    sos_mode = 1'b1;
    step(1);
    chk("t5_sos_leds", leds(), 8'h00);
    chk("t5_sos_idle", 8'(dut.state_reg), 8'(IDLE));
    chk("t5_sos_goal", 8'(goal_floor), 8'h00);
    chk("t5_sos_dir", 8'(direction), 8'h00);
    button2 = 1'b1;
    step(LAT + 2);
    chk("t5_sos_press_ignored", leds(), 8'h00);
    button2 = 1'b0;
    step(2);
    sos_mode = 1'b0;
    step(LAT + 2);
    chk("t5_after_sos", leds(), 8'h00);

    // Overload: presses latch, state frozen
    weight_limit_exceeded = 1'b1;
    button3 = 1'b1;
    step(LAT + 1);
    chk("t6_led3_latched", leds(), 8'h04);
    button3 = 1'b0;
    step(2);
    chk("t6_frozen_idle", 8'(dut.state_reg), 8'(IDLE));
    chk("t6_goal_cur", 8'(goal_floor), 8'h00);
    weight_limit_exceeded = 1'b0;
    step(1);
    chk("t6_up", 8'(dut.state_reg), 8'(UP));
    chk("t6_goal_f3", 8'(goal_floor), 8'h02);

    // Multi-hot and zero floor inputs hold the tracked floor
    {floor3, floor2, floor1} = 3'b011;
    step(2);
    chk("t7_multihot_hold", 8'(dut.cur_reg), 8'(F1));
    {floor3, floor2, floor1} = 3'b000;
    step(2);
    chk("t7_zero_hold", 8'(dut.cur_reg), 8'(F1));
    {floor3, floor2, floor1} = 3'b010;
    step(1);
    chk("t7_track_f2", 8'(dut.cur_reg), 8'(F2));

    // Asynchronous reset between clock edges
    #2;
    button_reset_n = 1'b0;
    #1;
    chk("t8_async_leds", leds(), 8'h00);
    chk("t8_async_state", 8'(dut.state_reg), 8'(IDLE));
    chk("t8_async_dir", 8'(direction), 8'h00);
    step(1);
    button_reset_n = 1'b1;
    {floor3, floor2, floor1} = 3'b001;
    step(2);

`ifdef REQUEST_SCHED_DEBOUNCE_EN
    button2 = 1'b1;
    step(2);
    button2 = 1'b0;
    step(12);
    chk("t9_glitch_dropped", leds(), 8'h00);
    button2 = 1'b1;
    step(LAT);
    chk("t9_led2_early", leds(), 8'h00);
    step(1);
    chk("t9_led2_set", leds(), 8'h02);
    step(2);
    button2 = 1'b0;
    step(8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
